// File: rtl/quiz_round_arbiter.sv
// ---------------------------------------------------------------------------
// quiz_round_arbiter
//   Clocked controller for the two-player arithmetic quiz. It steps through the
//   questions, decides who answered first (left or right joystick), keeps both
//   scores and declares the winner when the game ends.
// ---------------------------------------------------------------------------
module quiz_round_arbiter #(
   parameter int NUM_Q          = 9,     // questions per game (1..9)
   parameter int TIMEOUT_CYCLES = 1000,  // ASK cycles before a question is forfeited
   parameter int SHOW_CYCLES    = 100,   // cycles a result stays on display
   parameter int TW             = 16     // timer width, holds both cycle counts
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [8:0] joy_left,
   input  logic [8:0] joy_right,
   input  logic [8:0] answer,
   output logic [3:0] q_index,
   output logic       busy,
   output logic       show,
   output logic [1:0] result,
   output logic       point_left,
   output logic       point_right,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic       game_over,
   output logic [1:0] winner
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ASK  = 2'd1,
      S_SHOW = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
   localparam logic [3:0]    Q_LAST       = 4'(NUM_Q - 1);
   localparam logic [3:0]    SCORE_MAX    = 4'd9;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t        r_state;
   state_t        w_next_state;

   logic [8:0]    r_prev_left;     // joystick value seen on the previous cycle
   logic [8:0]    r_prev_right;
   logic          r_lock_left;     // player answered wrong on this question
   logic          r_lock_right;
   logic          r_prio;          // tie-break owner: 0 = left, 1 = right
   logic [TW-1:0] r_timer;
   logic [3:0]    r_q_index;
   logic [3:0]    r_score_left;
   logic [3:0]    r_score_right;
   logic [1:0]    r_result;        // {right scored, left scored} of the last question
   logic          r_point_left;
   logic          r_point_right;

   // ------------------------------------------------------------------------
   // Press classification
   // ------------------------------------------------------------------------
   logic w_press_left,   w_press_right;
   logic w_match_left,   w_match_right;
   logic w_correct_left, w_correct_right;
   logic w_wrong_left,   w_wrong_right;
   logic w_win_left,     w_win_right;
   logic w_tie;
   logic w_scored;
   logic w_lock_left_nxt, w_lock_right_nxt;
   logic w_all_locked;
   logic w_timeout;
   logic w_ask_exit;
   logic w_show_end;
   logic w_last_q;

   // A multi-bit press can never be a correct answer, even if it covers the key.
   function automatic logic is_onehot(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

   // A press is the edge from "nothing held" to "something held"; a button that
   // stays down (including one held through start) never produces a second press.
   assign w_press_left  = (r_prev_left  == 9'd0) && (joy_left  != 9'd0) && !r_lock_left;
   assign w_press_right = (r_prev_right == 9'd0) && (joy_right != 9'd0) && !r_lock_right;

   assign w_match_left  = is_onehot(joy_left)  && (joy_left  == answer);
   assign w_match_right = is_onehot(joy_right) && (joy_right == answer);

   assign w_correct_left  = w_press_left  &&  w_match_left;
   assign w_correct_right = w_press_right &&  w_match_right;
   assign w_wrong_left    = w_press_left  && !w_match_left;
   assign w_wrong_right   = w_press_right && !w_match_right;

   // Simultaneous correct answers go to the priority holder; priority then flips.
   assign w_tie       = w_correct_left && w_correct_right;
   assign w_win_left  = w_correct_left  && (!w_correct_right || !r_prio);
   assign w_win_right = w_correct_right && (!w_correct_left  ||  r_prio);
   assign w_scored    = w_win_left || w_win_right;

   assign w_lock_left_nxt  = r_lock_left  || w_wrong_left;
   assign w_lock_right_nxt = r_lock_right || w_wrong_right;
   assign w_all_locked     = w_lock_left_nxt && w_lock_right_nxt;

   // A score in the final ASK cycle wins over the timeout: both lead to SHOW,
   // and the result field is taken from the scoring flags.
   assign w_timeout  = (r_timer == TIMEOUT_LAST);
   assign w_ask_exit = w_scored || w_all_locked || w_timeout;
   assign w_show_end = (r_timer == SHOW_LAST);
   assign w_last_q   = (r_q_index == Q_LAST);

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next-state decision
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: if (start)      w_next_state = S_ASK;
         S_ASK:          if (w_ask_exit) w_next_state = S_SHOW;
         S_SHOW:         if (w_show_end) w_next_state = w_last_q ? S_DONE : S_ASK;
         default:                        w_next_state = S_IDLE;
      endcase
   end

   // FSM-decoded outputs
   always_comb begin
      busy      = 1'b0;
      show      = 1'b0;
      game_over = 1'b0;
      result    = 2'b00;
      winner    = 2'b00;
      unique case (r_state)
         S_ASK: busy = 1'b1;
         S_SHOW: begin
            busy   = 1'b1;
            show   = 1'b1;
            result = r_result;
         end
         S_DONE: begin
            game_over = 1'b1;
            if (r_score_left > r_score_right)      winner = 2'b01;
            else if (r_score_right > r_score_left) winner = 2'b10;
            else                                   winner = 2'b11;
         end
         default: ;
      endcase
   end

   // Game datapath: joystick history, timer, lockouts, question index and scores
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_left   <= 9'd0;
         r_prev_right  <= 9'd0;
         r_lock_left   <= 1'b0;
         r_lock_right  <= 1'b0;
         r_prio        <= 1'b0;
         r_timer       <= '0;
         r_q_index     <= 4'd0;
         r_score_left  <= 4'd0;
         r_score_right <= 4'd0;
         r_result      <= 2'b00;
         r_point_left  <= 1'b0;
         r_point_right <= 1'b0;
      end else begin
         // History is kept in every state so presses held across start are seen.
         r_prev_left   <= joy_left;
         r_prev_right  <= joy_right;
         r_point_left  <= 1'b0;
         r_point_right <= 1'b0;

         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  // Priority deliberately survives from game to game.
                  r_q_index     <= 4'd0;
                  r_score_left  <= 4'd0;
                  r_score_right <= 4'd0;
                  r_lock_left   <= 1'b0;
                  r_lock_right  <= 1'b0;
                  r_timer       <= '0;
                  r_result      <= 2'b00;
               end
            end

            S_ASK: begin
               r_timer      <= r_timer + 1'b1;
               r_lock_left  <= w_lock_left_nxt;
               r_lock_right <= w_lock_right_nxt;
               if (w_tie) r_prio <= ~r_prio;
               if (w_win_left) begin
                  r_point_left <= 1'b1;
                  if (r_score_left != SCORE_MAX) r_score_left <= r_score_left + 4'd1;
               end
               if (w_win_right) begin
                  r_point_right <= 1'b1;
                  if (r_score_right != SCORE_MAX) r_score_right <= r_score_right + 4'd1;
               end
               if (w_ask_exit) begin
                  r_timer  <= '0;
                  r_result <= {w_win_right, w_win_left};
               end
            end

            S_SHOW: begin
               r_timer <= r_timer + 1'b1;
               if (w_show_end) begin
                  r_timer <= '0;
                  if (!w_last_q) begin
                     r_q_index    <= r_q_index + 4'd1;
                     r_lock_left  <= 1'b0;
                     r_lock_right <= 1'b0;
                  end
               end
            end

            default: ;
         endcase
      end
   end

   assign q_index     = r_q_index;
   assign score_left  = r_score_left;
   assign score_right = r_score_right;
   assign point_left  = r_point_left;
   assign point_right = r_point_right;

endmodule
